pixel_op_stream: RTL

//  Parametrised streaming successor of the per-pixel processing stage. Sits between image_read and image_write.

---
 rtl/pixel_op_pkg.sv | 22 ++
 rtl/pixel_op_alu.sv | 100 ++++++++++
 rtl/pixel_op_stream.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_op_pkg.sv
// Shared opcodes, luma weights and FSM encoding for the streaming pixel stage.
// Optional clip statistics are enabled with `PIXEL_OP_STATS_EN.
package pixel_op_pkg;

  localparam int OP_PASS   = 0;
  localparam int OP_BRIGHT = 1;
  localparam int OP_GRAY   = 2;
  localparam int OP_INVERT = 3;
  localparam int OP_THRESH = 4;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_op_alu.sv
// Combinational per-pixel operation: PASS/BRIGHT/GRAY/INVERT/THRESH.
// Clip flags exist only when `PIXEL_OP_STATS_EN is defined.
module pixel_op_alu
  import pixel_op_pkg::*;
#(
  parameter int CH_W     = 8,
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] op,
  input  logic [CH_W-1:0]     param,
  input  logic [CH_W-1:0]     px_r,
  input  logic [CH_W-1:0]     px_g,
  input  logic [CH_W-1:0]     px_b,
`ifdef PIXEL_OP_STATS_EN
  output logic [2:0]          clip,
`endif
  output logic [CH_W-1:0]     res_r,
  output logic [CH_W-1:0]     res_g,
  output logic [CH_W-1:0]     res_b
);

  localparam logic [CH_W-1:0] MAX = '1;

  logic [CH_W+9:0] y_sum;
  logic [CH_W-1:0] y;

  function automatic logic signed [CH_W+1:0] bsum(
    input logic [CH_W-1:0] v,
    input logic [CH_W-1:0] p
  );
    return signed'({2'b00, v}) + signed'({{2{p[CH_W-1]}}, p});
  endfunction

  function automatic logic [CH_W-1:0] bsat(
    input logic [CH_W-1:0] v,
    input logic [CH_W-1:0] p
  );
    logic signed [CH_W+1:0] s;
    s = bsum(v, p);
    if (s[CH_W+1])    return '0;
    else if (s[CH_W]) return MAX;
    else              return s[CH_W-1:0];
  endfunction

`ifdef PIXEL_OP_STATS_EN
  function automatic logic bclip(
    input logic [CH_W-1:0] v,
    input logic [CH_W-1:0] p
  );
    logic signed [CH_W+1:0] s;
    s = bsum(v, p);
    return (s < 0) || (s > signed'({2'b00, MAX}));
  endfunction
`endif

  // weights sum to 256, so the >>8 result always fits CH_W bits
  assign y_sum = (CH_W+10)'(LUMA_R) * (CH_W+10)'(px_r)
               + (CH_W+10)'(LUMA_G) * (CH_W+10)'(px_g)
               + (CH_W+10)'(LUMA_B) * (CH_W+10)'(px_b);
  assign y = CH_W'(y_sum >> 8);

  always_comb begin
    res_r = px_r;
    res_g = px_g;
    res_b = px_b;
`ifdef PIXEL_OP_STATS_EN
    clip = '0;
`endif
    unique case (1'b1)
      (op == OPCODE_W'(OP_PASS)): ;
      (op == OPCODE_W'(OP_BRIGHT)): begin
        res_r = bsat(px_r, param);
        res_g = bsat(px_g, param);
        res_b = bsat(px_b, param);
`ifdef PIXEL_OP_STATS_EN
        clip = {bclip(px_r, param),
                bclip(px_g, param),
                bclip(px_b, param)};
`endif
      end
      (op == OPCODE_W'(OP_GRAY)): begin
        res_r = y;
        res_g = y;
        res_b = y;
      end
      (op == OPCODE_W'(OP_INVERT)): begin
        res_r = MAX - px_r;
        res_g = MAX - px_g;
        res_b = MAX - px_b;
      end
      (op == OPCODE_W'(OP_THRESH)): begin
        res_r = (y >= param) ? MAX : '0;
        res_g = res_r;
        res_b = res_r;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pixel_op_stream.sv
// Streaming pixel stage: START-latched op, 2-cycle pipeline, ROW/COL/SOF/EOF tags.
// `PIXEL_OP_STATS_EN adds STAT_CLIP_CNT (BRIGHT clip count per frame).
module pixel_op_stream
  import pixel_op_pkg::*;
#(
  parameter int CH_W     = 8,
  parameter int DIM_W    = 12,
  parameter int OPCODE_W = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic [CH_W-1:0]     PARAM,
  input  logic [DIM_W-1:0]    WIDTH,
  input  logic [DIM_W-1:0]    HEIGHT,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [CH_W-1:0]     IN_RED,
  input  logic [CH_W-1:0]     IN_GREEN,
  input  logic [CH_W-1:0]     IN_BLUE,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [CH_W-1:0]     OUT_RED,
  output logic [CH_W-1:0]     OUT_GREEN,
  output logic [CH_W-1:0]     OUT_BLUE,
  output logic [DIM_W-1:0]    OUT_ROW,
  output logic [DIM_W-1:0]    OUT_COL,
  output logic                OUT_SOF,
  output logic                OUT_EOF,
  output logic                BUSY,
`ifdef PIXEL_OP_STATS_EN
  output logic [2*DIM_W+1:0]  STAT_CLIP_CNT,
`endif
  output logic                FRAME_DONE
);

  state_t state, state_nxt;

  logic [OPCODE_W-1:0] op_q;
  logic [CH_W-1:0]     param_q;
  logic [DIM_W-1:0]    width_q, height_q;
  logic [DIM_W-1:0]    row, col;
  logic                en, in_fire, last, start_ok;

  logic                s1_valid, s1_sof, s1_eof;
  logic [CH_W-1:0]     s1_r, s1_g, s1_b;
  logic [DIM_W-1:0]    s1_row, s1_col;
  logic [CH_W-1:0]     a_r, a_g, a_b;
`ifdef PIXEL_OP_STATS_EN
  logic [2:0]          a_clip;
`endif

  assign en       = !OUT_VALID || OUT_READY;
  assign in_fire  = IN_VALID && IN_READY;
  assign start_ok = (state == ST_IDLE) && START;
  assign last     = (row == height_q - DIM_W'(1))
                 && (col == width_q - DIM_W'(1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (START)
          state_nxt = (WIDTH == '0 || HEIGHT == '0)
                    ? ST_DONE : ST_RUN;
      ST_RUN:
        if (in_fire && last) state_nxt = ST_DRAIN;
      ST_DRAIN:
        if (OUT_VALID && OUT_READY && OUT_EOF)
          state_nxt = ST_DONE;
      ST_DONE:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    IN_READY   = 1'b0;
    BUSY       = 1'b0;
    FRAME_DONE = 1'b0;
    unique case (state)
      ST_RUN: begin
        IN_READY = en;
        BUSY     = 1'b1;
      end
      ST_DRAIN: BUSY       = 1'b1;
      ST_DONE:  FRAME_DONE = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op_q     <= '0;
      param_q  <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else if (start_ok) begin
      op_q     <= OPCODE;
      param_q  <= PARAM;
      width_q  <= WIDTH;
      height_q <= HEIGHT;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      row <= '0;
      col <= '0;
    end else if (start_ok) begin
      row <= '0;
      col <= '0;
    end else if (in_fire) begin
      if (col == width_q - DIM_W'(1)) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  // tags are gated by the handshake so idle bubbles never carry SOF/EOF
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
    end else if (en) begin
      s1_valid <= in_fire;
      s1_sof   <= in_fire && row == '0 && col == '0;
      s1_eof   <= in_fire && last;
      s1_r     <= IN_RED;
      s1_g     <= IN_GREEN;
      s1_b     <= IN_BLUE;
      s1_row   <= row;
      s1_col   <= col;
    end
  end

  pixel_op_alu #(
    .CH_W     (CH_W),
    .OPCODE_W (OPCODE_W)
  ) u_alu (
    .op    (op_q),
    .param (param_q),
    .px_r  (s1_r),
    .px_g  (s1_g),
    .px_b  (s1_b),
`ifdef PIXEL_OP_STATS_EN
    .clip  (a_clip),
`endif
    .res_r (a_r),
    .res_g (a_g),
    .res_b (a_b)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      OUT_VALID <= 1'b0;
      OUT_SOF   <= 1'b0;
      OUT_EOF   <= 1'b0;
      OUT_RED   <= '0;
      OUT_GREEN <= '0;
      OUT_BLUE  <= '0;
      OUT_ROW   <= '0;
      OUT_COL   <= '0;
    end else if (en) begin
      OUT_VALID <= s1_valid;
      OUT_SOF   <= s1_sof;
      OUT_EOF   <= s1_eof;
      OUT_RED   <= a_r;
      OUT_GREEN <= a_g;
      OUT_BLUE  <= a_b;
      OUT_ROW   <= s1_row;
      OUT_COL   <= s1_col;
    end
  end

`ifdef PIXEL_OP_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      STAT_CLIP_CNT <= '0;
    else if (start_ok)
      STAT_CLIP_CNT <= '0;
    else if (en && s1_valid)
      STAT_CLIP_CNT <= STAT_CLIP_CNT
                     + (2*DIM_W+2)'(a_clip[0])
                     + (2*DIM_W+2)'(a_clip[1])
                     + (2*DIM_W+2)'(a_clip[2]);
  end
`endif

endmodule
